// File: rtl/seg7_scan_if.sv
// Display-side bus of the 7-segment scan controller: the value to show (digits/dp/en)
// and the board pin drive (AN/CA) with the per-frame load strobe.
interface seg7_scan_if;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [3:0]  AN;
    logic [7:0]  CA;
    logic        frame_tick;

    modport master (output digits, dp, en, input AN, CA, frame_tick);
    modport slave  (input digits, dp, en, output AN, CA, frame_tick);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with per-slot blanking and per-frame shadowing.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zero digits 3..1.
module seg7_scan_ctrl #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        clear,
    seg7_scan_if.slave  bus
);
    typedef enum logic {BLANK, DRIVE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] slot_cnt, cnt_nx;
    logic [1:0]       dig_idx, idx_nx;
    logic [15:0]      sh_digits, digits_nx;
    logic [3:0]       sh_dp, dp_nx, sh_en, en_nx, lit_mask;
    logic [3:0]       nib_nx;
    logic             wrap, load;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    endfunction

    // Outputs are registered, so everything is computed for the cycle about to begin.
    always_comb begin
        wrap      = (slot_cnt == LAST_CNT);
        cnt_nx    = wrap ? '0 : slot_cnt + 1'b1;
        idx_nx    = wrap ? dig_idx + 2'd1 : dig_idx;
        load      = wrap && (dig_idx == 2'd3);
        digits_nx = load ? bus.digits : sh_digits;
        dp_nx     = load ? bus.dp     : sh_dp;
        en_nx     = load ? bus.en     : sh_en;
        nib_nx    = digits_nx[{idx_nx, 2'b00} +: 4];
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic zero_above;
    always_comb begin
        lit_mask   = en_nx;
        zero_above = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            zero_above = zero_above && (digits_nx[i*4 +: 4] == 4'h0);
            if (zero_above && !dp_nx[i])
                lit_mask[i] = 1'b0;
        end
    end
`else
    always_comb begin
        lit_mask = en_nx;
    end
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            state          <= BLANK;
            slot_cnt       <= '0;
            dig_idx        <= 2'd0;
            sh_digits      <= '0;
            sh_dp          <= '0;
            sh_en          <= '0;
            bus.AN         <= 4'b1111;
            bus.CA         <= 8'hFF;
            bus.frame_tick <= 1'b0;
        end else begin
            slot_cnt       <= cnt_nx;
            dig_idx        <= idx_nx;
            sh_digits      <= digits_nx;
            sh_dp          <= dp_nx;
            sh_en          <= en_nx;
            bus.frame_tick <= (idx_nx == 2'd3) && (cnt_nx == LAST_CNT);
            case (state)
                BLANK: if (cnt_nx == BLANK_CNT) state <= DRIVE;
                DRIVE: if (wrap)                state <= BLANK;
                default:                        state <= BLANK;
            endcase
            if (cnt_nx >= BLANK_CNT && lit_mask[idx_nx]) begin
                bus.AN <= ~(4'b0001 << idx_nx);
                bus.CA <= {~dp_nx[idx_nx], hex_seg(nib_nx)};
            end else begin
                bus.AN <= 4'b1111;
                bus.CA <= 8'hFF;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SLOT_CYCLES=8, BLANK_CYCLES=2; frames checked cycle by cycle.
module tb_seg7_scan_ctrl;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic [3:0]      en;
        logic [3:0][3:0] an;
        logic [3:0][7:0] ca;
    } vec_t;

    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    seg7_scan_if sif();

    seg7_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .CNT_W(4)) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks one whole frame starting at the cycle holding slot 0, count 0.
    task automatic check_frame(input logic content, input logic [3:0][3:0] ean,
                               input logic [3:0][7:0] eca, input int chg_cyc,
                               input logic [15:0] chg_val);
        for (int c = 0; c < 4*SLOT; c++) begin
            int s, k;
            s = c / SLOT;
            k = c % SLOT;
            if (c == chg_cyc) sif.digits = chg_val;
            chk("frame_tick", 32'(sif.frame_tick), 32'(c == 4*SLOT-1));
            chk("one_an_low", 32'($countones(~sif.AN) <= 1), 32'd1);
            if (k < BLANK) begin
                chk("blank_an", 32'(sif.AN), 32'hF);
                if (content) chk("blank_ca", 32'(sif.CA), 32'hFF);
            end else if (content) begin
                chk("drive_an", 32'(sif.AN), 32'(ean[s]));
                chk("drive_ca", 32'(sif.CA), 32'(eca[s]));
            end
            step();
        end
    endtask

    localparam logic [3:0][3:0] DARK_AN = {4'hF, 4'hF, 4'hF, 4'hF};
    localparam logic [3:0][7:0] DARK_CA = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    localparam logic [3:0][3:0] ALL_AN  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    initial begin
        vecs.push_back('{16'h8888, 4'b0100, 4'b0101,
                         {4'hF, 4'b1011, 4'hF, 4'b1110}, {8'hFF, 8'h00, 8'hFF, 8'h80}});
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        vecs.push_back('{16'h0042, 4'b0000, 4'hF,
                         {4'hF, 4'hF, 4'b1101, 4'b1110}, {8'hFF, 8'hFF, 8'h99, 8'hA4}});
        vecs.push_back('{16'h0000, 4'b0000, 4'hF,
                         {4'hF, 4'hF, 4'hF, 4'b1110}, {8'hFF, 8'hFF, 8'hFF, 8'hC0}});
        vecs.push_back('{16'h0042, 4'b0100, 4'hF,
                         {4'hF, 4'b1011, 4'b1101, 4'b1110}, {8'hFF, 8'h40, 8'h99, 8'hA4}});
`else
        vecs.push_back('{16'h0042, 4'b0000, 4'hF,
                         ALL_AN, {8'hC0, 8'hC0, 8'h99, 8'hA4}});
`endif

        clear = 1'b1;
        sif.digits = 16'h0;
        sif.dp = 4'h0;
        sif.en = 4'h0;
        repeat (3) step();
        chk("reset_an", 32'(sif.AN), 32'hF);
        chk("reset_ca", 32'(sif.CA), 32'hFF);
        chk("reset_tick", 32'(sif.frame_tick), 32'd0);

        // First frame dark, then 1234 with an ABCD update arriving during digit 1.
        sif.digits = 16'h1234;
        sif.en = 4'hF;
        clear = 1'b0;
        check_frame(1'b1, DARK_AN, DARK_CA, -1, 16'h0);
        check_frame(1'b1, ALL_AN, {8'hF9, 8'hA4, 8'hB0, 8'h99}, SLOT + 3, 16'hABCD);
        check_frame(1'b1, ALL_AN, {8'h88, 8'h83, 8'hC6, 8'hA1}, -1, 16'h0);

        // Abort mid DRIVE of digit 2 (showing 'b').
        repeat (2*SLOT + 4) step();
        chk("mid_an", 32'(sif.AN), 32'b1011);
        chk("mid_ca", 32'(sif.CA), 32'h83);
        clear = 1'b1;
        step();
        chk("abort_an", 32'(sif.AN), 32'hF);
        chk("abort_ca", 32'(sif.CA), 32'hFF);
        chk("abort_tick", 32'(sif.frame_tick), 32'd0);
        clear = 1'b0;
        check_frame(1'b1, DARK_AN, DARK_CA, -1, 16'h0);

        foreach (vecs[i]) begin
            sif.digits = vecs[i].digits;
            sif.dp = vecs[i].dp;
            sif.en = vecs[i].en;
            check_frame(1'b0, DARK_AN, DARK_CA, -1, 16'h0);
            check_frame(1'b1, vecs[i].an, vecs[i].ca, -1, 16'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
